// File: rtl/us_pkg.sv
// Shared types and helpers for the us_interp upsampler.
// Fill behaviour is selected at build time by US_HOLD_EN.
package us_pkg;

  localparam int DATA_W = 62;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE,
    EMIT
  } us_state_t;

  function automatic int phase_w(int l);
    return (l > 1) ? $clog2(l) : 1;
  endfunction

endpackage

// File: rtl/us_phase_cnt.sv
// Output phase counter for the upsampler: 0..L-1.
// load restarts at phase 0; adv steps and wraps only on the last phase.
module us_phase_cnt
  import us_pkg::*;
#(
  parameter int L = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  adv,
  output logic [phase_w(L)-1:0] phase,
  output logic                  last
);

  localparam int PW = phase_w(L);

  logic [PW-1:0] r_phase;
  logic          w_last;

  assign w_last = (r_phase == PW'(L - 1));
  assign phase  = r_phase;
  assign last   = w_last;

  // Phase register: a new sample restarts, a transfer steps forward.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_phase <= '0;
    end else if (adv) begin
      r_phase <= w_last ? '0 : r_phase + PW'(1);
    end
  end

endmodule

// File: rtl/us_interp.sv
// Upsample-by-L for complex samples with valid/ready on both sides.
// US_HOLD_EN: fill phases repeat the held sample instead of 0+0j.
module us_interp
  import us_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int L = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] in_real,
  input  logic signed [W-1:0] in_imag,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_real,
  output logic signed [W-1:0] out_imag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_first
);

  localparam int PW = phase_w(L);

  if (L < 1) begin : g_bad_l
    $error("us_interp: L must be >= 1");
  end

  us_state_t           r_state;
  us_state_t           w_state_nx;
  logic signed [W-1:0] r_re;
  logic signed [W-1:0] r_im;
  logic signed [W-1:0] w_re_nx;
  logic signed [W-1:0] w_im_nx;
  logic signed [W-1:0] w_fill_re;
  logic signed [W-1:0] w_fill_im;
  logic [PW-1:0]       w_phase;
  logic                w_last;
  logic                w_out_valid;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_adv;

  assign w_out_valid = (r_state == EMIT);
  assign in_ready    = !w_out_valid || (out_ready && w_last);
  assign w_in_xfer   = in_valid && in_ready;
  assign w_out_xfer  = w_out_valid && out_ready;
  assign w_adv       = w_out_xfer && !w_in_xfer;

  us_phase_cnt #(
    .L(L)
  ) u_phase (
    .clk  (clk),
    .reset(reset),
    .load (w_in_xfer),
    .adv  (w_adv),
    .phase(w_phase),
    .last (w_last)
  );

`ifdef US_HOLD_EN
  logic signed [W-1:0] r_hold_re;
  logic signed [W-1:0] r_hold_im;

  // Capture each accepted sample for the zero-order-hold fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_re <= '0;
      r_hold_im <= '0;
    end else if (w_in_xfer) begin
      r_hold_re <= in_real;
      r_hold_im <= in_imag;
    end
  end

  assign w_fill_re = r_hold_re;
  assign w_fill_im = r_hold_im;
`else
  assign w_fill_re = '0;
  assign w_fill_im = '0;
`endif

  // Next state and next output sample from the two handshakes.
  always_comb begin
    w_state_nx = r_state;
    w_re_nx    = r_re;
    w_im_nx    = r_im;
    unique case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          w_state_nx = EMIT;
          w_re_nx    = in_real;
          w_im_nx    = in_imag;
        end
      end
      EMIT: begin
        if (w_in_xfer) begin
          w_re_nx = in_real;
          w_im_nx = in_imag;
        end else if (w_out_xfer) begin
          if (w_last) begin
            w_state_nx = IDLE;
            w_re_nx    = '0;
            w_im_nx    = '0;
          end else begin
            w_re_nx = w_fill_re;
            w_im_nx = w_fill_im;
          end
        end
      end
    endcase
  end

  // State and output registers; stalls simply keep them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_re    <= '0;
      r_im    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_re    <= w_re_nx;
      r_im    <= w_im_nx;
    end
  end

  assign out_valid = w_out_valid;
  assign out_real  = r_re;
  assign out_imag  = r_im;
  assign out_first = w_out_valid && (w_phase == '0);

endmodule
